// File: rtl/decode_queue_stage.sv
// decode_queue_stage
//   RV32I decode stage fronted by a small instruction queue. Fetch pushes
//   {pc, inst, pred} through a valid/ready handshake. The head of the queue
//   is decoded and, when the hazard unit allows it, loaded into the ID/EX
//   register that the EX/MEM/WB stages consume.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   flush                     discard queue and ID/EX contents
//   in_valid/in_ready         fetch handshake (in_ready = queue not full)
//   in_pc/in_inst/in_pred     fetch entry
//   rs1_addr/rs2_addr         regfile read addresses taken from the queue head
//   rs1_data/rs2_data         combinational regfile read data
//   wb_en/wb_rd/wb_data       writeback port, used for operand bypass
//   stall                     hold ID/EX register and queue head
//   q_count                   queue occupancy
//   out_*                     registered ID/EX control bundle
module decode_queue_stage #(
    parameter int PTR_W  = 2,
    parameter bit EN_CSR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    input  logic             in_pred,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_data,
    input  logic             stall,
    output logic [PTR_W:0]   q_count,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pcp4,
    output logic [31:0]      out_imm,
    output logic [31:0]      out_rs1_data,
    output logic [31:0]      out_rs2_data,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_wb_ctrl,
    output logic [1:0]       out_mem_rw,
    output logic [2:0]       out_branch,
    output logic [2:0]       out_alu_src,
    output logic [3:0]       out_alu_ctrl,
    output logic [2:0]       out_funct3,
    output logic             out_is_csr,
    output logic             out_is_ecall,
    output logic             out_is_mret,
    output logic [11:0]      out_csr,
    output logic             out_pred,
    output logic             out_illegal
);
    localparam int DEPTH = 2 ** PTR_W;
    localparam logic [PTR_W:0]   FULL_CNT = {1'b1, {PTR_W{1'b0}}};
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // Writeback result targets this source register (x0 is never bypassed).
    function automatic logic wb_hit(input logic en, input logic [4:0] rd, input logic [4:0] rs);
        return en && (rd != 5'd0) && (rd == rs);
    endfunction

    // ALU operation for OP / OP-IMM; only register-register ops can subtract.
    function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic bit30, input logic is_op);
        logic [3:0] alu;
        case (f3)
            3'b000:  alu = (is_op && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  alu = ALU_SLL;
            3'b010:  alu = ALU_SLT;
            3'b011:  alu = ALU_SLTU;
            3'b100:  alu = ALU_XOR;
            3'b101:  alu = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  alu = ALU_OR;
            default: alu = ALU_AND;
        endcase
        return alu;
    endfunction

    logic [31:0]      q_pc_r   [DEPTH];
    logic [31:0]      q_inst_r [DEPTH];
    logic             q_pred_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [4:0]       held_rs1_r, held_rs2_r;

    logic             full_s, push_s, pop_s;
    logic [31:0]      head_inst_s;
    logic [2:0]       f3_s;
    logic [31:0]      imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [2:0]       dec_wb_s, dec_br_s, dec_asrc_s;
    logic [1:0]       dec_mem_s;
    logic [3:0]       dec_alu_s;
    logic [31:0]      dec_imm_s;
    logic [4:0]       dec_rd_s;
    logic [11:0]      dec_csrno_s;
    logic             dec_csr_s, dec_ecall_s, dec_mret_s, dec_ill_s;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign full_s      = (count_r == FULL_CNT);
    assign in_ready    = ~full_s;
    assign push_s      = in_valid && !full_s && !flush;
    assign pop_s       = (count_r != '0) && !stall && !flush;
    assign q_count     = count_r;
    assign head_inst_s = q_inst_r[rd_ptr_r];
    assign rs1_addr    = head_inst_s[19:15];
    assign rs2_addr    = head_inst_s[24:20];
    assign f3_s        = head_inst_s[14:12];

    assign imm_i_s = {{20{head_inst_s[31]}}, head_inst_s[31:20]};
    assign imm_s_s = {{20{head_inst_s[31]}}, head_inst_s[31:25], head_inst_s[11:7]};
    assign imm_b_s = {{19{head_inst_s[31]}}, head_inst_s[31], head_inst_s[7],
                      head_inst_s[30:25], head_inst_s[11:8], 1'b0};
    assign imm_u_s = {head_inst_s[31:12], 12'd0};
    assign imm_j_s = {{11{head_inst_s[31]}}, head_inst_s[31], head_inst_s[19:12],
                      head_inst_s[20], head_inst_s[30:21], 1'b0};

    // Queue storage, pointers and occupancy; flush empties the queue and drops the push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_r[i]   <= 32'd0;
                q_inst_r[i] <= 32'd0;
                q_pred_r[i] <= 1'b0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                q_pc_r[wr_ptr_r]   <= in_pc;
                q_inst_r[wr_ptr_r] <= in_inst;
                q_pred_r[wr_ptr_r] <= in_pred;
                wr_ptr_r           <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Decode of the queue head; an illegal word leaves every control at zero.
    always_comb begin
        dec_wb_s    = 3'd0;
        dec_mem_s   = 2'd0;
        dec_br_s    = 3'd0;
        dec_asrc_s  = 3'd0;
        dec_alu_s   = ALU_ADD;
        dec_imm_s   = 32'd0;
        dec_rd_s    = 5'd0;
        dec_csrno_s = 12'd0;
        dec_csr_s   = 1'b0;
        dec_ecall_s = 1'b0;
        dec_mret_s  = 1'b0;
        dec_ill_s   = 1'b0;
        case (head_inst_s[6:0])
            OP_LUI: begin
                dec_wb_s = 3'b100; dec_imm_s = imm_u_s; dec_rd_s = head_inst_s[11:7];
            end
            OP_AUIPC: begin
                dec_wb_s = 3'b100; dec_asrc_s = 3'b100; dec_imm_s = imm_u_s;
                dec_rd_s = head_inst_s[11:7];
            end
            OP_JAL: begin
                dec_wb_s = 3'b110; dec_br_s = 3'b111; dec_asrc_s = 3'b100;
                dec_imm_s = imm_j_s; dec_rd_s = head_inst_s[11:7];
            end
            OP_JALR: begin
                dec_wb_s = 3'b110; dec_br_s = 3'b111; dec_asrc_s = 3'b010;
                dec_imm_s = imm_i_s; dec_rd_s = head_inst_s[11:7];
            end
            OP_LOAD: begin
                dec_wb_s = 3'b101; dec_mem_s = 2'b10; dec_asrc_s = 3'b010;
                dec_imm_s = imm_i_s; dec_rd_s = head_inst_s[11:7];
            end
            OP_OPIMM: begin
                dec_wb_s   = 3'b100;
                dec_asrc_s = 3'b010;
                // Immediate shifts carry a 5-bit shamt; inst[30] selects SRA instead.
                dec_imm_s  = (f3_s == 3'b101) ? {27'd0, head_inst_s[24:20]} : imm_i_s;
                dec_alu_s  = alu_arith(f3_s, head_inst_s[30], 1'b0);
                dec_rd_s   = head_inst_s[11:7];
            end
            OP_BRANCH: begin
                if (f3_s[2:1] == 2'b01) begin
                    dec_ill_s = 1'b1;
                end else begin
                    dec_asrc_s = 3'b011;
                    dec_imm_s  = imm_b_s;
                    dec_alu_s  = f3_s[2] ? (f3_s[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                    case (f3_s)
                        3'b000:  dec_br_s = 3'b001;
                        3'b001:  dec_br_s = 3'b010;
                        3'b100:  dec_br_s = 3'b011;
                        3'b101:  dec_br_s = 3'b100;
                        3'b110:  dec_br_s = 3'b101;
                        default: dec_br_s = 3'b110;
                    endcase
                end
            end
            OP_STORE: begin
                dec_mem_s = 2'b01; dec_asrc_s = 3'b010; dec_imm_s = imm_s_s;
            end
            OP_OP: begin
                dec_wb_s   = 3'b100;
                dec_asrc_s = 3'b011;
                dec_alu_s  = alu_arith(f3_s, head_inst_s[30], 1'b1);
                dec_rd_s   = head_inst_s[11:7];
            end
            OP_SYSTEM: begin
                if (EN_CSR) begin
                    dec_wb_s    = (f3_s == 3'b000) ? 3'b000 : 3'b100;
                    dec_asrc_s  = 3'b010;
                    dec_imm_s   = {27'd0, head_inst_s[19:15]};
                    dec_rd_s    = head_inst_s[11:7];
                    dec_csrno_s = head_inst_s[31:20];
                    dec_csr_s   = (f3_s != 3'b000);
                    dec_ecall_s = (f3_s == 3'b000) && (head_inst_s[31:20] == 12'h000);
                    dec_mret_s  = (f3_s == 3'b000) && (head_inst_s[31:20] == 12'h302);
                end else begin
                    dec_ill_s = 1'b1;
                end
            end
            default: dec_ill_s = 1'b1;
        endcase
    end

    // ID/EX register: flush > stall (hold, with writeback bypass) > advance > bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            out_valid <= 1'b0; out_pc <= 32'd0; out_pcp4 <= 32'd0; out_imm <= 32'd0;
            out_rs1_data <= 32'd0; out_rs2_data <= 32'd0; out_rd <= 5'd0;
            out_wb_ctrl <= 3'd0; out_mem_rw <= 2'd0; out_branch <= 3'd0;
            out_alu_src <= 3'd0; out_alu_ctrl <= 4'd0; out_funct3 <= 3'd0;
            out_is_csr <= 1'b0; out_is_ecall <= 1'b0; out_is_mret <= 1'b0;
            out_csr <= 12'd0; out_pred <= 1'b0; out_illegal <= 1'b0;
            held_rs1_r <= 5'd0; held_rs2_r <= 5'd0;
        end else if (stall) begin
            // Operands keep tracking writeback so a long stall does not read stale data.
            if (wb_hit(wb_en, wb_rd, held_rs1_r)) out_rs1_data <= wb_data;
            if (wb_hit(wb_en, wb_rd, held_rs2_r)) out_rs2_data <= wb_data;
        end else if (pop_s) begin
            out_valid    <= 1'b1;
            out_pc       <= q_pc_r[rd_ptr_r];
            out_pcp4     <= q_pc_r[rd_ptr_r] + 32'd4;
            out_imm      <= dec_imm_s;
            out_rs1_data <= wb_hit(wb_en, wb_rd, rs1_addr) ? wb_data : rs1_data;
            out_rs2_data <= wb_hit(wb_en, wb_rd, rs2_addr) ? wb_data : rs2_data;
            out_rd       <= dec_rd_s;
            out_wb_ctrl  <= dec_wb_s;
            out_mem_rw   <= dec_mem_s;
            out_branch   <= dec_br_s;
            out_alu_src  <= dec_asrc_s;
            out_alu_ctrl <= dec_alu_s;
            out_funct3   <= dec_ill_s ? 3'd0 : f3_s;
            out_is_csr   <= dec_csr_s;
            out_is_ecall <= dec_ecall_s;
            out_is_mret  <= dec_mret_s;
            out_csr      <= dec_csrno_s;
            out_pred     <= q_pred_r[rd_ptr_r];
            out_illegal  <= dec_ill_s;
            held_rs1_r   <= rs1_addr;
            held_rs2_r   <= rs2_addr;
        end else begin
            out_valid <= 1'b0; out_pc <= 32'd0; out_pcp4 <= 32'd0; out_imm <= 32'd0;
            out_rs1_data <= 32'd0; out_rs2_data <= 32'd0; out_rd <= 5'd0;
            out_wb_ctrl <= 3'd0; out_mem_rw <= 2'd0; out_branch <= 3'd0;
            out_alu_src <= 3'd0; out_alu_ctrl <= 4'd0; out_funct3 <= 3'd0;
            out_is_csr <= 1'b0; out_is_ecall <= 1'b0; out_is_mret <= 1'b0;
            out_csr <= 12'd0; out_pred <= 1'b0; out_illegal <= 1'b0;
            held_rs1_r <= 5'd0; held_rs2_r <= 5'd0;
        end
    end

endmodule

// File: doc/decode_queue_stage.md
Name: decode_queue_stage

Overview:
Parametrised RV32I decode stage with an instruction queue (DEPTH entries) between fetch and decode. It uses a valid/ready handshake on the fetch side and a stall/flush interface from the hazard unit. It produces the same ID/EX control bundle the EX/MEM/WB stages already consume. It adds writeback bypass during stall and an illegal-opcode flag.

Parameters:
PTR_W, 2, queue pointer width; DEPTH = 2**PTR_W entries (PTR_W >= 1).
EN_CSR, 1, 1 = decode SYSTEM opcode (CSR/ecall/mret); 0 = treat 1110011 as illegal.

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  discard queue and ID/EX contents
in_valid  in  1  fetch entry valid
in_ready  out  1  queue can accept (= !full)
in_pc  in  32  fetch PC
in_inst  in  32  instruction word
in_pred  in  1  branch-predicted-taken bit
rs1_addr, rs2_addr  out  5  regfile read addresses, head-of-queue inst[19:15]/[24:20]
rs1_data, rs2_data  in  32  combinational regfile read data
wb_en  in  1  WB writing regfile this cycle
wb_rd  in  5  WB destination
wb_data  in  32  WB data
stall  in  1  hold ID/EX register and queue head
q_count  out  PTR_W+1  occupancy
out_valid  out  1  ID/EX holds a real instruction
out_pc, out_pcp4, out_imm, out_rs1_data, out_rs2_data  out  32 each
out_rd  out  5
out_wb_ctrl  out  3  [2] regwrite, [1:0] memtoreg
out_mem_rw  out  2  10 load, 01 store
out_branch  out  3  000 none, 001 eq, 010 ne, 011 lt, 100 ge, 101 ltu, 110 geu, 111 jump
out_alu_src  out  3
out_alu_ctrl  out  4  ALU_* codes from define.v
out_funct3  out  3
out_is_csr, out_is_ecall, out_is_mret  out  1
out_csr  out  12
out_pred  out  1
out_illegal  out  1

Behaviour:
- Reset: queue empty; every ID/EX output is 0. in_ready=1 once rst is released.
- Queue:
  - Push when in_valid && in_ready.
  - Pop ("advance") when count>0 && !stall && !flush.
  - Simultaneous push and pop leaves count unchanged.
  - Full: in_ready=0 even if a pop occurs that cycle (no combinational ready path).
  - Pointers wrap modulo DEPTH.
- ID/EX register, updated on the clk edge. Priority: flush > stall > advance > bubble.
  - flush: queue cleared, the same-cycle push is dropped, ID/EX loads a bubble (all outputs 0).
  - stall: all fields held, except out_rs1_data/out_rs2_data. These reload wb_data when wb_en && wb_rd != 0 && wb_rd equals the held rs1/rs2 address, which is stored internally.
  - advance: load the decoded head; out_valid=1; out_pcp4 = pc+4.
    - Operand data = wb_data when wb_en && wb_rd != 0 && wb_rd == rsN_addr; otherwise rsN_data.
  - No advance and no stall (empty queue): bubble.
- Decode, by opcode. Listed as wb_ctrl / mem_rw / branch / alu_src; imm per RV32I format.
  - LUI: 100/00/000/000.
  - AUIPC: 100/00/000/100.
  - JAL: 110/00/111/100.
  - JALR: 110/00/111/010.
  - LOAD: 101/10/000/010.
  - OP-IMM: 100/00/000/010. For funct3 101, imm is zero-extended inst[24:20].
  - BRANCH: 000/00/funct3-mapped/011; rd forced to 0. funct3 010/011 is illegal.
  - STORE: 000/01/000/010; rd forced to 0.
  - OP: 100/00/000/011; imm=0.
  - SYSTEM (EN_CSR=1): wb_ctrl is 000 if funct3==0, else 100. alu_src=010, imm = zero-extended inst[19:15], out_csr = inst[31:20].
    - is_ecall: funct3==0 && csr==0x000.
    - is_mret: funct3==0 && csr==0x302.
- alu_ctrl:
  - BRANCH: funct3 11x → SLTU, 10x → SLT, otherwise SUB.
  - OP/OP-IMM: mapped by funct3. SUB only for OP with inst[30]=1; SRA when inst[30]=1 for funct3 101.
  - All other opcodes: ADD.
- Illegal opcode: out_valid=1, out_illegal=1, all controls 0, rd=0. The queue still pops; trapping is downstream.
- Reset mid-operation is asynchronous: queue empties and outputs clear immediately.

Test Plan:
1. Reset, then push 0x00500093 (addi x1,x0,5) at PC 0x100 → next edge after pop: out_valid=1, out_wb_ctrl=100, out_alu_src=010, out_imm=5, out_rd=1, out_pcp4=0x104.
2. Push 0x00208463 (beq x1,x2,+8) with rs1_data=rs2_data=7 → out_branch=001, out_imm=8, out_alu_ctrl=ALU_SUB, out_rd=0.
3. Hold stall=1, push DEPTH+1 instructions → q_count=DEPTH, in_ready=0, extra entry not accepted; release stall → entries drain in order, one per cycle.
4. Advance 0x0040A183 (lw x3,4(x1)), then assert stall with wb_en=1, wb_rd=1, wb_data=0xDEAD → out_rs1_data becomes 0xDEAD while other fields hold; out_mem_rw=10, out_wb_ctrl=101.
5. Queue 3 entries, assert flush together with in_valid → q_count=0, out_valid=0, all controls 0, pushed entry lost.
6. Push 0x30200073 (mret) → out_is_mret=1, out_wb_ctrl=000. With EN_CSR=0 the same word gives out_illegal=1. Push 0xFFFFFFFF → out_illegal=1.
